// File: rtl/vector_scanner.sv
// Leading-one scanner: accepts a 32-bit vector and emits one beat per set bit, MSB first.
// Optional beat counter output cnt_out is enabled by defining VECTOR_SCANNER_CNT_EN.
module vector_scanner #(
   parameter int DATA_W = 32,
   parameter int POS_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [POS_W-1:0]  out_pos,
   output logic              out_last,
   output logic              busy
`ifdef VECTOR_SCANNER_CNT_EN
   ,
   output logic [POS_W-1:0]  cnt_out
`endif
);

   typedef enum logic [1:0] {IDLE, SCAN, ZERO} state_t;

   state_t            state;
   logic [DATA_W-1:0] vec;
   logic [DATA_W-1:0] lead_mask;
   logic [POS_W-1:0]  lead_pos;
   logic              single;

   // Priority encoder: the highest set bit wins because it is visited last.
   always_comb begin
      lead_pos  = POS_W'(DATA_W);
      lead_mask = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (vec[i]) begin
            lead_pos  = POS_W'(DATA_W - 1 - i);
            lead_mask = DATA_W'(1) << i;
         end
      end
   end

   assign single   = (vec != '0) && ((vec & (vec - DATA_W'(1))) == '0);
   assign out_pos  = lead_pos;
   assign out_last = single | (state == ZERO);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         vec       <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
`ifdef VECTOR_SCANNER_CNT_EN
         cnt_out   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  vec       <= in_data;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= (in_data != '0) ? SCAN : ZERO;
`ifdef VECTOR_SCANNER_CNT_EN
                  cnt_out   <= '0;
`endif
               end
            end
            SCAN: begin
               if (out_ready) begin
                  vec <= vec & ~lead_mask;
`ifdef VECTOR_SCANNER_CNT_EN
                  cnt_out <= cnt_out + POS_W'(1);
`endif
                  if (single) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
            end
            ZERO: begin
               // The zero beat carries no set bit, so the counter is left alone.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               vec       <= '0;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_scanner.sv
// Scoreboard bench for vector_scanner: expected beats are queued on load and popped on each handshake.
// Define VECTOR_SCANNER_CNT_EN for both files to exercise cnt_out.
module tb_vector_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [5:0]  out_pos;
   logic        out_last;
   logic        busy;
`ifdef VECTOR_SCANNER_CNT_EN
   logic [5:0]  cnt_out;
`endif

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc_cyc;
   logic [6:0]  sb[$];

   vector_scanner #(.DATA_W(32), .POS_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pos   (out_pos),
      .out_last  (out_last),
      .busy      (busy)
`ifdef VECTOR_SCANNER_CNT_EN
      ,
      .cnt_out   (cnt_out)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every handshake away from reset must match the oldest queued beat.
   always @(negedge clk) begin
      logic [6:0] exp;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_beat: got pos=%0d last=%0b, required no beat", out_pos, out_last);
         end else begin
            exp = sb.pop_front();
            if ({out_last, out_pos} !== exp) begin
               errors++;
               $display("[TB] FAIL beat: got pos=%0d last=%0b, required pos=%0d last=%0b",
                        out_pos, out_last, exp[5:0], exp[6]);
            end
         end
      end
   end

   // Offers a vector, queues its expected beats, and returns just after the accepting edge.
   task automatic load(input logic [31:0] d);
      int  n;
      bit  ok;
      ok = 1'b0;
      n = $countones(d);
      if (d == 32'h0) sb.push_back({1'b1, 6'd32});
      else begin
         for (int i = 31; i >= 0; i--) begin
            if (d[i]) begin
               n--;
               sb.push_back({(n == 0), 6'(31 - i)});
            end
         end
      end
      in_valid = 1'b1;
      in_data  = d;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      in_data  = $urandom;
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, out_pos, out_last, busy} !== {1'b0, 6'd32, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reset_state: got valid=%0b pos=%0d last=%0b busy=%0b, required 0/32/0/0",
                  out_valid, out_pos, out_last, busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready: got in_ready=%0b, required 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_two_bits;
      out_ready = 1'b1;
      load(32'h8000_0001);
      @(negedge clk);
      checks++;
      if ({out_valid, out_pos, out_last} !== {1'b1, 6'd0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL two_bits_first: got valid=%0b pos=%0d last=%0b, required 1/0/0",
                  out_valid, out_pos, out_last);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, busy, sb.size() == 0} !== 4'b0101) begin
         errors++;
         $display("[TB] FAIL two_bits_idle: got valid=%0b ready=%0b busy=%0b pending=%0d, required 0/1/0/0",
                  out_valid, in_ready, busy, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero;
      load(32'h0);
      @(negedge clk);
      checks++;
      if ({out_valid, out_pos, out_last, busy} !== {1'b1, 6'd32, 1'b1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL zero_beat: got valid=%0b pos=%0d last=%0b busy=%0b, required 1/32/1/1",
                  out_valid, out_pos, out_last, busy);
      end
`ifdef VECTOR_SCANNER_CNT_EN
      checks++;
      if (cnt_out !== 6'd0) begin
         errors++;
         $display("[TB] FAIL zero_cnt_during: got %0d, required 0", cnt_out);
      end
`endif
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL zero_idle: got valid=%0b ready=%0b, required 0/1", out_valid, in_ready);
      end
`ifdef VECTOR_SCANNER_CNT_EN
      checks++;
      if (cnt_out !== 6'd0) begin
         errors++;
         $display("[TB] FAIL zero_cnt_after: got %0d, required 0", cnt_out);
      end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic test_stall;
      out_ready = 1'b0;
      load(32'h0001_0000);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, out_pos, out_last} !== {1'b1, 6'd15, 1'b1}) begin
            errors++;
            $display("[TB] FAIL stall_hold_%0d: got valid=%0b pos=%0d last=%0b, required 1/15/1",
                     k, out_valid, out_pos, out_last);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, busy, sb.size() == 0} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL stall_release: got valid=%0b busy=%0b pending=%0d, required 0/0/0",
                  out_valid, busy, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_all_ones;
      bit ok;
      out_ready = 1'b1;
      load(32'hFFFF_FFFF);
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if ({in_ready, busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL all_ones_busy_%0d: got ready=%0b busy=%0b, required 0/1", k, in_ready, busy);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_done(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL all_ones_drain: got %0d beats pending, required 0", sb.size());
         sb.delete();
      end
`ifdef VECTOR_SCANNER_CNT_EN
      checks++;
      if (cnt_out !== 6'd32) begin
         errors++;
         $display("[TB] FAIL all_ones_cnt: got %0d, required 32", cnt_out);
      end
`endif
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b1;
      load(32'hF000_0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 2) begin
         errors++;
         $display("[TB] FAIL mid_reset_beats: got %0d beats pending, required 2", sb.size());
      end
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, out_pos, busy, in_ready} !== {1'b0, 6'd32, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mid_reset_state_%0d: got valid=%0b pos=%0d busy=%0b ready=%0b, required 0/32/0/1",
                     k, out_valid, out_pos, busy, in_ready);
         end
`ifdef VECTOR_SCANNER_CNT_EN
         checks++;
         if (cnt_out !== 6'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_cnt_%0d: got %0d, required 0", k, cnt_out);
         end
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      int c0;
      int c1;
      bit ok;
      out_ready = 1'b1;
      load(32'h0000_0003);
      c0 = acc_cyc;
      load(32'h0);
      c1 = acc_cyc;
      checks++;
      if (c1 - c0 != 3) begin
         errors++;
         $display("[TB] FAIL b2b_two_bit_gap: got %0d cycles, required 3", c1 - c0);
      end
      load(32'h0000_0001);
      checks++;
      if (acc_cyc - c1 != 2) begin
         errors++;
         $display("[TB] FAIL b2b_zero_gap: got %0d cycles, required 2", acc_cyc - c1);
      end
      wait_done(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL b2b_drain: got %0d beats pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      test_reset();
      test_two_bits();
      test_zero();
      test_stall();
      test_all_ones();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
